// File: rtl/rpi_inst_scheduler_if.sv
// rpi_inst_scheduler_if: instruction dispatch handshake between the SPI
// front end (master) and the accelerator datapath (slave).
`timescale 1ns/1ps
interface rpi_inst_scheduler_if #(
    parameter int unsigned N = 80
);
    logic [N-1:0] inst_data;
    logic         inst_valid;
    logic         inst_ready;

    modport master (output inst_data, output inst_valid, input inst_ready);
    modport slave  (input inst_data, input inst_valid, output inst_ready);
endinterface

// File: rtl/rpi_inst_scheduler.sv
// rpi_inst_scheduler: oversamples the Pi SPI lines, assembles cs1-framed
// N-bit instructions, qualifies frame length, buffers good frames in a
// 2-entry queue and dispatches them over a valid/ready handshake.
// Optional even-parity qualification (bit 0 is the parity bit): define
// RPI_INST_PARITY_EN.
`timescale 1ns/1ps
module rpi_inst_scheduler #(
    parameter int unsigned N     = 80,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 MOSI,
    input  logic                 RPiclk,
    input  logic                 cs1,
    rpi_inst_scheduler_if.master inst_if,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_err_cnt,
    output logic [CNT_W-1:0]     overflow_cnt
);
    localparam int unsigned     BC_W = $clog2(N + 2);
    localparam logic [BC_W-1:0] BC_N = BC_W'(N);

    typedef enum logic [1:0] {S_WAIT_HI, S_IDLE, S_SHIFT, S_COMMIT} state_t;

    logic [1:0]       mosi_q;
    logic [2:0]       rclk_q;
    logic [2:0]       cs_q;
    logic             mosi_s;
    logic             cs_s;
    logic             rclk_rise;
    logic             cs_rise;
    logic             cs_fall;
    state_t           state_q, state_d;
    logic [N-1:0]     shift_q, shift_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic             parity_ok;
    logic             commit_good;
    logic             commit_bad;
    logic [N-1:0]     head_q, head_d;
    logic [N-1:0]     tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic [CNT_W-1:0] ferr_q, ferr_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;
    logic             pop;
    logic             push;

    // Synchronisers; cs1 resets low so a frame in flight at reset release
    // never looks like a fresh falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mosi_q <= '0;
            rclk_q <= '0;
            cs_q   <= '0;
        end else begin
            mosi_q <= {mosi_q[0], MOSI};
            rclk_q <= {rclk_q[1:0], RPiclk};
            cs_q   <= {cs_q[1:0], cs1};
        end
    end

    assign mosi_s    = mosi_q[1];
    assign cs_s      = cs_q[1];
    assign rclk_rise = rclk_q[1] & ~rclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];

`ifdef RPI_INST_PARITY_EN
    assign parity_ok = ~^shift_q;
`else
    assign parity_ok = 1'b1;
`endif

    // Frame FSM: next state, shift register and bit counter.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        commit_good = 1'b0;
        commit_bad  = 1'b0;
        unique case (state_q)
            S_WAIT_HI: begin
                if (cs_s) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (cs_fall) begin
                    state_d   = S_SHIFT;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            S_SHIFT: begin
                if (cs_rise) begin
                    state_d = S_COMMIT;
                end else if (rclk_rise) begin
                    if (bit_cnt_q < BC_N)  shift_d   = {shift_q[N-2:0], mosi_s};
                    if (bit_cnt_q <= BC_N) bit_cnt_d = bit_cnt_q + BC_W'(1);
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                if (bit_cnt_q == BC_N && parity_ok) commit_good = 1'b1;
                else                                commit_bad  = 1'b1;
            end
            default: state_d = S_WAIT_HI;
        endcase
    end

    assign pop  = (occ_q != 2'd0) && inst_if.inst_ready;
    assign push = commit_good && ((occ_q != 2'd2) || pop);

    // Queue next state; head always holds the oldest entry.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = shift_q;
                else               tail_d = shift_q;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = shift_q;
                end else begin
                    head_d = tail_q;
                    tail_d = shift_q;
                end
            end
            default: ;
        endcase
    end

    // Saturating error counters.
    always_comb begin
        ferr_d = ferr_q;
        ovf_d  = ovf_q;
        if (commit_bad && ferr_q != '1)                 ferr_d = ferr_q + CNT_W'(1);
        if (commit_good && !push && ovf_q != '1)        ovf_d  = ovf_q + CNT_W'(1);
    end

    // State, queue and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_WAIT_HI;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
            ferr_q    <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign inst_if.inst_data  = head_q;
    assign inst_if.inst_valid = (occ_q != 2'd0);
    assign busy               = (state_q == S_SHIFT) || (state_q == S_COMMIT) || (occ_q != 2'd0);
    assign frame_err_cnt      = ferr_q;
    assign overflow_cnt       = ovf_q;
endmodule

// File: tb/tb_rpi_inst_scheduler.sv
// tb_rpi_inst_scheduler: random SPI frames against a queue-based reference
// model; DUT outputs compared every cycle plus literal spot checks.
`timescale 1ns/1ps
module tb_rpi_inst_scheduler;
    localparam int unsigned N     = 80;
    localparam int unsigned CNT_W = 3;
    localparam int          SAT   = 7;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             MOSI;
    logic             RPiclk;
    logic             cs1;
    logic             busy;
    logic [CNT_W-1:0] frame_err_cnt;
    logic [CNT_W-1:0] overflow_cnt;

    rpi_inst_scheduler_if #(.N(N)) bus_if ();

    rpi_inst_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .MOSI          (MOSI),
        .RPiclk        (RPiclk),
        .cs1           (cs1),
        .inst_if       (bus_if),
        .busy          (busy),
        .frame_err_cnt (frame_err_cnt),
        .overflow_cnt  (overflow_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: pins seen through a 3-sample delay line, frame
    // assembled as a bit list, dispatch queue as an SV queue.
    logic [N-1:0] mq[$];
    bit           m_bits[$];
    bit           m_armed, m_in_frame, m_commit, was_commit, good;
    int           m_ferr, m_ovf;
    logic [2:0]   hcs, hck, hmo;
    logic [N-1:0] w;
    logic [N-1:0] popped[$];
    int           popped_cyc[$];
    int           cyc = 0;
    int           valid_cycles = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_bits.delete();
            m_armed = 0; m_in_frame = 0; m_commit = 0;
            m_ferr = 0; m_ovf = 0;
            hcs = '0; hck = '0; hmo = '0;
        end else begin
            cyc++;
            if (bus_if.inst_valid) valid_cycles++;
            if (bus_if.inst_valid && bus_if.inst_ready) begin
                popped.push_back(bus_if.inst_data);
                popped_cyc.push_back(cyc);
            end
            was_commit = m_commit;
            m_commit = 0;
            if (mq.size() > 0 && bus_if.inst_ready) void'(mq.pop_front());
            if (was_commit) begin
                w = '0;
                foreach (m_bits[k]) w = {w[N-2:0], m_bits[k]};
                good = (m_bits.size() == N);
`ifdef RPI_INST_PARITY_EN
                good = good && ((^w) == 1'b0);
`endif
                if (!good)               begin if (m_ferr < SAT) m_ferr++; end
                else if (mq.size() < 2)  mq.push_back(w);
                else if (m_ovf < SAT)    m_ovf++;
            end
            // hcs[1]/hcs[2] are the pin levels two and three samples ago.
            if (was_commit) begin
            end else if (!m_armed) begin
                if (hcs[1]) m_armed = 1;
            end else if (!m_in_frame) begin
                if (!hcs[1] && hcs[2]) begin m_in_frame = 1; m_bits.delete(); end
            end else if (hcs[1] && !hcs[2]) begin
                m_in_frame = 0;
                m_commit = 1;
            end else if (hck[1] && !hck[2] && m_bits.size() <= N) begin
                m_bits.push_back(hmo[1]);
            end
            hcs = {hcs[1:0], cs1};
            hck = {hck[1:0], RPiclk};
            hmo = {hmo[1:0], MOSI};
        end
    end

    int unsigned vecs = 0;
    int unsigned errs = 0;

    task automatic chk_i(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk_i("inst_valid", int'(bus_if.inst_valid), (mq.size() > 0) ? 1 : 0);
            if (mq.size() > 0) chk_w("inst_data", bus_if.inst_data, mq[0]);
            chk_i("busy", int'(busy), (m_in_frame || m_commit || mq.size() > 0) ? 1 : 0);
            chk_i("frame_err_cnt", int'(frame_err_cnt), m_ferr);
            chk_i("overflow_cnt", int'(overflow_cnt), m_ovf);
        end
    endtask

    function automatic logic [N-1:0] rand_frame();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
`ifdef RPI_INST_PARITY_EN
        r[0] = r[0] ^ (^r[N-1:0]);
`endif
        return r[N-1:0];
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        @(negedge clk);
        cs1 = 1'b0;
        idle($urandom_range(4, 8));
    endtask

    // Sends data[nbits-1:0], MSB first, one RPiclk period per bit.
    task automatic send_seq(input logic [127:0] data, input int nbits);
        int hp;
        hp = $urandom_range(4, 6);
        for (int i = nbits - 1; i >= 0; i--) begin
            MOSI = data[i];
            idle(hp);
            RPiclk = 1'b1;
            idle(hp);
            RPiclk = 1'b0;
        end
    endtask

    task automatic frame_end();
        idle($urandom_range(4, 8));
        cs1 = 1'b1;
        idle(20);
    endtask

    task automatic send_bits(input logic [127:0] data, input int nbits);
        frame_start();
        send_seq(data, nbits);
        frame_end();
    endtask

    task automatic send_word(input logic [N-1:0] d);
        send_bits({48'd0, d}, N);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        idle(10);
    endtask

    logic [N-1:0] lit, f1, f2, f3, g;
    int           pbase, vbase;
    bit           seen, stop;

    initial begin
`ifdef RPI_INST_PARITY_EN
        lit = 80'hA5_0123456789ABCDEF00;
`else
        lit = 80'hA5_0123456789ABCDEF01;
`endif
        reset_n = 1'b0; cs1 = 1'b1; RPiclk = 1'b0; MOSI = 1'b0;
        bus_if.inst_ready = 1'b1;
        idle(3);
        chk_i("rst_valid", int'(bus_if.inst_valid), 0);
        chk_w("rst_data", bus_if.inst_data, '0);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_ferr", int'(frame_err_cnt), 0);
        chk_i("rst_ovf", int'(overflow_cnt), 0);
        fork compare_loop(); join_none
        @(posedge clk);
        #2 reset_n = 1'b1;
        idle(10);

        // Single frame, inst_ready held high.
        pbase = popped.size(); vbase = valid_cycles;
        send_word(lit);
        chk_i("single_pops", popped.size() - pbase, 1);
        if (popped.size() > pbase) chk_w("single_data", popped[pbase], lit);
        chk_i("single_valid_cycles", valid_cycles - vbase, 1);
        chk_i("single_ferr", int'(frame_err_cnt), 0);
        chk_i("single_ovf", int'(overflow_cnt), 0);

        // Short then long frame.
        pbase = popped.size();
        send_bits({48'd0, rand_frame()}, N - 1);
        send_bits({47'd0, rand_frame(), 1'b1}, N + 1);
        chk_i("len_pops", popped.size() - pbase, 0);
        chk_i("len_ferr", int'(frame_err_cnt), 2);

        // Backpressure and overflow.
        f1 = rand_frame(); f2 = rand_frame(); f3 = rand_frame();
        bus_if.inst_ready = 1'b0;
        send_word(f1); send_word(f2); send_word(f3);
        chk_i("bp_valid", int'(bus_if.inst_valid), 1);
        chk_w("bp_head", bus_if.inst_data, f1);
        chk_i("bp_ovf", int'(overflow_cnt), 1);
        pbase = popped.size();
        bus_if.inst_ready = 1'b1;
        idle(6);
        chk_i("bp_pops", popped.size() - pbase, 2);
        if (popped.size() >= pbase + 2) begin
            chk_w("bp_first", popped[pbase], f1);
            chk_w("bp_second", popped[pbase + 1], f2);
            chk_i("bp_gap", popped_cyc[pbase + 1] - popped_cyc[pbase], 1);
        end

        // Push and pop in the same cycle while full.
        do_reset();
        f1 = rand_frame(); f2 = rand_frame(); f3 = rand_frame();
        bus_if.inst_ready = 1'b0;
        send_word(f1); send_word(f2);
        pbase = popped.size();
        seen = 0;
        fork
            send_word(f3);
            begin
                for (int c = 0; c < 3000 && !seen; c++) begin
                    @(negedge clk);
                    if (m_commit) begin bus_if.inst_ready = 1'b1; seen = 1; end
                end
            end
        join
        chk_i("pp_commit_seen", int'(seen), 1);
        idle(6);
        chk_i("pp_ovf", int'(overflow_cnt), 0);
        chk_i("pp_pops", popped.size() - pbase, 3);
        if (popped.size() >= pbase + 3) begin
            chk_w("pp_1", popped[pbase], f1);
            chk_w("pp_2", popped[pbase + 1], f2);
            chk_w("pp_3", popped[pbase + 2], f3);
        end

        // Reset in the middle of a frame.
        g = rand_frame();
        pbase = popped.size(); vbase = valid_cycles;
        frame_start();
        send_seq({48'd0, g} >> 40, 40);
        do_reset();
        send_seq({48'd0, g}, 40);
        frame_end();
        chk_i("mid_pops", popped.size() - pbase, 0);
        chk_i("mid_valid_cycles", valid_cycles - vbase, 0);
        chk_i("mid_ferr", int'(frame_err_cnt), 0);
        chk_i("mid_ovf", int'(overflow_cnt), 0);
        send_word(g);
        chk_i("mid_next_pops", popped.size() - pbase, 1);
        if (popped.size() > pbase) chk_w("mid_next_data", popped[pbase], g);

`ifdef RPI_INST_PARITY_EN
        // Single flipped bit fails parity; the intact frame is dispatched.
        do_reset();
        g = rand_frame();
        f1 = g; f1[17] = ~f1[17];
        pbase = popped.size();
        send_word(f1);
        chk_i("par_ferr", int'(frame_err_cnt), 1);
        chk_i("par_bad_pops", popped.size() - pbase, 0);
        send_word(g);
        chk_i("par_good_pops", popped.size() - pbase, 1);
        if (popped.size() > pbase) chk_w("par_good_data", popped[pbase], g);
`endif

        // Random lengths with random backpressure.
        stop = 0;
        fork
            begin
                for (int f = 0; f < 10; f++) begin
                    case ($urandom_range(0, 5))
                        0:       send_bits({48'd0, rand_frame()}, N - 1);
                        1:       send_bits({47'd0, rand_frame(), 1'b0}, N + 1);
                        2:       send_bits('0, 0);
                        default: send_word(rand_frame());
                    endcase
                end
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(negedge clk);
                    bus_if.inst_ready = ($urandom_range(0, 3) == 0);
                end
            end
        join
        bus_if.inst_ready = 1'b1;
        idle(8);

        // Counter saturation.
        do_reset();
        for (int f = 0; f < 9; f++) send_bits('0, 0);
        chk_i("sat_ferr", int'(frame_err_cnt), SAT);
        bus_if.inst_ready = 1'b0;
        for (int f = 0; f < 11; f++) send_word(rand_frame());
        chk_i("sat_ovf", int'(overflow_cnt), SAT);
        chk_i("sat_ferr_hold", int'(frame_err_cnt), SAT);
        bus_if.inst_ready = 1'b1;
        idle(6);
        chk_i("sat_drained", int'(bus_if.inst_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected finish before %0d", 900000);
        $fatal(1);
    end
endmodule

// File: doc/rpi_inst_scheduler.md
# rpi_inst_scheduler

Front-end controller for the Raspberry Pi instruction path on the DE10-Lite accelerator. It oversamples the Pi's SPI lines (MOSI, RPiclk, cs1) in the FPGA system clock domain and assembles each chip-select framed transfer into an N-bit instruction word. It qualifies the frame length and buffers complete instructions in a 2-entry queue. It then dispatches them to the accelerator datapath over a valid/ready handshake, and counts framing and overflow errors for status readback.

## Interface
- N, 80, instruction width in bits; MSB is received first.
- CNT_W, 8, width of each saturating error counter.
- clk  input  1  FPGA system clock. Must be ≥ 8× the RPiclk frequency.
- reset_n  input  1  asynchronous, active-low reset.
- MOSI  input  1  Pi serial data, asynchronous to clk.
- RPiclk  input  1  Pi SPI clock, asynchronous to clk. Idle low; data is sampled on its rising edge.
- cs1  input  1  Pi chip select, active low, asynchronous to clk.
- inst_data  output  N  head-of-queue instruction.
- inst_valid  output  1  queue not empty.
- inst_ready  input  1  datapath accepts inst_data this cycle.
- busy  output  1  a frame is in progress or the queue is non-empty.
- frame_err_cnt  output  CNT_W  saturating count of frames whose bit count ≠ N.
- overflow_cnt  output  CNT_W  saturating count of good frames dropped because the queue was full.

## Operation
- **Input synchronisation**
  - MOSI, RPiclk and cs1 each pass through a 2-flop synchroniser.
  - A third register on RPiclk and cs1 provides edge detection.
  - MOSI is taken from its synchroniser output.
- **Frame FSM** (states IDLE, SHIFT, COMMIT, WAIT_HI):
  - IDLE: move to SHIFT on a cs1 falling edge (synced). Clear the shift register and the bit counter.
  - SHIFT: on each RPiclk rising edge, shift_reg <= {shift_reg[N-2:0], MOSI} and increment bit_cnt.
    - bit_cnt saturates at N+1.
    - Edges beyond N shift nothing more and only mark the frame overlong.
  - SHIFT: move to COMMIT on a cs1 rising edge.
  - COMMIT (one cycle):
    - If bit_cnt == N and the frame passes the optional parity check: push to the queue, or increment overflow_cnt if the push is refused.
    - Otherwise increment frame_err_cnt.
    - Always return to IDLE.
  - WAIT_HI: entered from reset. Stays there until synced cs1 is high, then goes to IDLE. A frame already under way when reset releases is therefore never captured.
- **Queue**: 2 entries, registered storage.
  - inst_data is the head entry.
  - inst_valid = !empty.
  - A pop occurs when inst_valid && inst_ready.
  - A push is accepted when not full, or when full and a pop occurs in the same cycle.
  - Simultaneous push and pop keeps the occupancy unchanged.
- Both counters saturate at 2^CNT_W − 1 and never wrap.
- busy = (state == SHIFT || state == COMMIT || !empty).
- Reset values:
  - inst_valid 0; inst_data 0; busy 0.
  - frame_err_cnt 0; overflow_cnt 0.
  - Queue empty; FSM in WAIT_HI.

## Timing
- An input edge on a pin is visible as an internal edge strobe 3 clk cycles later.
- cs1 rising at the pin → COMMIT in cycle 4 → inst_valid high in cycle 5 (first frame into an empty queue).
- The COMMIT → IDLE turnaround is 1 cycle. The Pi's minimum cs1-high time is 2 RPiclk periods, which is ≥ 16 clk cycles.
- inst_data is stable while inst_valid is high and inst_ready is low.
- inst_data changes only on the cycle after a pop.
- Back-to-back pops drain the 2-entry queue in 2 cycles.
- A cs1 glitch narrower than 1 clk cycle may be missed.

## Configuration
- Macro: RPI_INST_PARITY_EN.
- **Defined**:
  - Bit 0 of each frame (the last bit received) is an even-parity bit covering all N bits.
  - A frame is good only if the XOR of all N bits is 0.
  - A parity failure increments frame_err_cnt and the frame is not pushed.
  - inst_data still presents the full N bits, parity bit included.
- **Undefined**: no parity logic is built, and length is the only qualification.

## Test plan
- **Single frame**: reset, then send 80 bits 0xA5 followed by 0x0123456789ABCDEF01 with inst_ready=1.
  - inst_valid pulses for 1 cycle with inst_data = that 80-bit value.
  - Both counters stay 0.
- **Short and long frames**: send a 79-bit frame, then an 81-bit frame.
  - No inst_valid.
  - frame_err_cnt = 2.
- **Backpressure and overflow**: hold inst_ready=0 and send 3 good frames.
  - inst_valid=1 with the first frame held on inst_data; overflow_cnt = 1.
  - Releasing inst_ready yields frames 1 then 2, on consecutive cycles.
- **Push and pop in the same cycle**: with the queue full, assert inst_ready exactly in the COMMIT cycle of frame 3.
  - Frame 3 is accepted; overflow_cnt stays 0.
  - Output order is 1, 2, 3.
- **Reset mid-frame**: assert reset_n=0 after 40 bits, release it with cs1 still low, and finish that frame.
  - No inst_valid and no counter change.
  - The next full frame is received correctly.
- **Parity** (with RPI_INST_PARITY_EN): send a frame with a single bit flipped.
  - frame_err_cnt increments and no inst_valid.
  - The same frame with correct parity is dispatched.
